execute_unit: RTL

- Execute stage directly downstream of the register file. Consumes the 32-bit instruction and the two 16-bit read operands (rs1, rs2).
- Decodes R-type and I-type integer ops and computes the result.
- Returns the result to the register-file write port as rd, data and a write strobe.
- Single-cycle ops complete with 1-cycle latency. MUL runs on an iterative shift-add FSM with a ready/busy handshake.

---
 rtl/execute_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/execute_unit.sv
// Integer execute stage: 1-cycle ALU ops and a 16-step shift-add multiply.
// Single-cycle ops write back one cycle after issue. ready is low while a MUL is in progress, and upstream holds issue until ready is high.
module execute_unit #(
    parameter int DATA_W     = 16,
    parameter bit MUL_ENABLE = 1'b1
) (
    input  logic              clock,
    input  logic              r,
    input  logic              issue,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              ready,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              illegal
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [0:0] {IDLE, MUL} state_t;

    state_t state, state_nxt;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm;
    logic        unused_rs1;

    assign opcode     = instruction[6:0];
    assign rd         = instruction[11:7];
    assign funct3     = instruction[14:12];
    assign funct7     = instruction[31:25];
    assign imm        = instruction[31:20];
    assign unused_rs1 = ^instruction[19:15];

    logic              is_r, is_i, dec_illegal, dec_mul, ext_bad;
    logic [DATA_W-1:0] imm_sx, src_b, alu_res;
    logic [SH_W-1:0]   shamt;

    logic [DATA_W-1:0] mcand, mplier, acc, acc_step;
    logic [CNT_W-1:0]  count;
    logic [4:0]        mul_rd;

    logic              accept, mul_start, wb_load, illegal_nxt;
    logic [DATA_W-1:0] wb_data_nxt;
    logic [4:0]        wb_rd_nxt;

    // Decode and single-cycle ALU; I-type shifts take shamt from the immediate.
    always_comb begin
        is_r        = (opcode == OP_R);
        is_i        = (opcode == OP_I);
        imm_sx      = {{(DATA_W-12){imm[11]}}, imm};
        src_b       = is_r ? op_b : imm_sx;
        shamt       = src_b[SH_W-1:0];
        ext_bad     = is_r && (funct7 != F7_BASE);
        alu_res     = '0;
        dec_illegal = 1'b0;
        dec_mul     = 1'b0;
        case (funct3)
            3'b000: begin
                if (is_r && funct7 == F7_MUL) begin
                    dec_mul     = MUL_ENABLE;
                    dec_illegal = !MUL_ENABLE;
                end else if (is_r && funct7 == F7_ALT) begin
                    alu_res = op_a - src_b;
                end else if (is_i || funct7 == F7_BASE) begin
                    alu_res = op_a + src_b;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            3'b001: begin
                alu_res     = op_a << shamt;
                dec_illegal = (funct7 != F7_BASE);
            end
            3'b010: begin
                alu_res     = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(src_b))};
                dec_illegal = ext_bad;
            end
            3'b011: begin
                alu_res     = {{(DATA_W-1){1'b0}}, (op_a < src_b)};
                dec_illegal = ext_bad;
            end
            3'b100: begin
                alu_res     = op_a ^ src_b;
                dec_illegal = ext_bad;
            end
            3'b101: begin
                if (funct7 == F7_BASE)     alu_res = op_a >> shamt;
                else if (funct7 == F7_ALT) alu_res = $signed(op_a) >>> shamt;
                else                       dec_illegal = 1'b1;
            end
            3'b110: begin
                alu_res     = op_a | src_b;
                dec_illegal = ext_bad;
            end
            3'b111: begin
                alu_res     = op_a & src_b;
                dec_illegal = ext_bad;
            end
        endcase
        if (!is_r && !is_i) begin
            dec_illegal = 1'b1;
            dec_mul     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (r) state <= IDLE;
        else   state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        ready       = (state == IDLE);
        accept      = issue && ready;
        mul_start   = 1'b0;
        wb_load     = 1'b0;
        illegal_nxt = 1'b0;
        wb_data_nxt = alu_res;
        wb_rd_nxt   = rd;
        acc_step    = mplier[0] ? acc + mcand : acc;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (dec_illegal) begin
                        illegal_nxt = 1'b1;
                    end else if (dec_mul) begin
                        mul_start = 1'b1;
                        state_nxt = MUL;
                    end else begin
                        wb_load = (rd != 5'd0);
                    end
                end
            end
            MUL: begin
                wb_data_nxt = acc_step;
                wb_rd_nxt   = mul_rd;
                if (count == LAST_STEP) begin
                    state_nxt = IDLE;
                    wb_load   = (mul_rd != 5'd0);
                end
            end
        endcase
    end

    // Write-back registers only change on a real write so they hold otherwise.
    always_ff @(posedge clock) begin
        if (r) begin
            wb_valid <= 1'b0;
            illegal  <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            count    <= '0;
            mul_rd   <= '0;
        end else begin
            wb_valid <= wb_load;
            illegal  <= illegal_nxt;
            if (wb_load) begin
                wb_data <= wb_data_nxt;
                wb_rd   <= wb_rd_nxt;
            end
            if (mul_start) begin
                mcand  <= op_a;
                mplier <= op_b;
                acc    <= '0;
                count  <= '0;
                mul_rd <= rd;
            end else if (state == MUL) begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
            end
        end
    end

endmodule
